pulse_seq: RTL and testbench

- Pulse-pattern sequencer placed directly downstream of the 8x8 pattern RAM.
- Walks the RAM table, holding read mode and driving address, and turns each 8-bit entry into one timed level segment on the optical sync output.
- Even entries are high segments; odd entries are low segments.
- A zero entry terminates the pattern. Optional looping repeats the table.

---
 rtl/pulse_seq_if.sv | 22 ++
 rtl/pulse_seq.sv | 158 +++++++++++++++
 tb/tb_pulse_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_seq_if.sv
// RAM-side bus between the pulse sequencer and the pattern RAM.
// Sequencer drives address and read/write select; RAM returns registered read data.
interface pulse_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_RW;
  logic [DATA_W-1:0] ram_data;

  modport master (
    output ram_addr,
    output ram_RW,
    input  ram_data
  );

  modport slave (
    input  ram_addr,
    input  ram_RW,
    output ram_data
  );
endinterface

// File: rtl/pulse_seq.sv
// Pulse-pattern sequencer: walks the pattern RAM and turns each entry into one
// timed level segment on pulse_out (even index high, odd index low, zero ends).
module pulse_seq #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic              clk_SEQ,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  pulse_seq_if.master       ram,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] seg_idx
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StHold} state_e;

  state_e            state_q, state_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Set when the last table entry finishes without looping: the final segment
  // still gets its two-cycle fetch tail so every segment lasts value+2 cycles.
  logic              tail_q, tail_d;

  logic data_zero;
  logic cnt_last;

  assign data_zero = (ram.ram_data == '0);
  assign cnt_last  = (cnt_q == DATA_W'(1));

  // State and datapath registers
  always_ff @(posedge clk_SEQ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      tail_q  <= tail_d;
    end
  end

  // Next-state logic; stop overrides every transition
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StFetch;
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          if (tail_q) begin
            state_d = StIdle;
          end else if (!data_zero) begin
            state_d = StHold;
          end else if ((idx_q == '0) || !loop_en) begin
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
        end
        StHold: begin
          if (cnt_last) state_d = StFetch;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered output and datapath next values
  always_comb begin
    pulse_d = pulse_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    tail_d  = tail_q;
    if (stop) begin
      pulse_d = 1'b0;
      tail_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pulse_d = 1'b0;
          if (start) begin
            idx_d  = '0;
            addr_d = '0;
            tail_d = 1'b0;
          end
        end
        StFetch: ;
        StLoad: begin
          if (tail_q) begin
            pulse_d = 1'b0;
            done_d  = 1'b1;
            tail_d  = 1'b0;
          end else if (!data_zero) begin
            pulse_d = ~idx_q[0];
            cnt_d   = ram.ram_data;
          end else begin
            pulse_d = 1'b0;
            // A zero at index 0 always ends, so looping never spins silently
            if ((idx_q == '0) || !loop_en) begin
              done_d = 1'b1;
            end else begin
              idx_d  = '0;
              addr_d = '0;
            end
          end
        end
        StHold: begin
          cnt_d = cnt_q - DATA_W'(1);
          if (cnt_last) begin
            if (idx_q < LastIdx) begin
              idx_d  = idx_q + ADDR_W'(1);
              addr_d = idx_q + ADDR_W'(1);
            end else if (loop_en) begin
              idx_d  = '0;
              addr_d = '0;
            end else begin
              tail_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram.ram_addr = addr_q;
  assign ram.ram_RW   = 1'b0;
  assign pulse_out    = pulse_q;
  assign done         = done_q;
  assign busy         = (state_q != StIdle);
  assign seg_idx      = idx_q;

endmodule

// File: tb/tb_pulse_seq.sv
// Self-checking bench for pulse_seq: a segment-level model fills a scoreboard of
// per-cycle {pulse_out, busy, done, ram_RW} samples that are popped each clock.
module tb_pulse_seq;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned NUM_ENTRIES = 8;

  logic              clk_SEQ = 1'b0;
  logic              rst_n   = 1'b1;
  logic              start   = 1'b0;
  logic              stop    = 1'b0;
  logic              loop_en = 1'b0;
  logic              pulse_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] seg_idx;

  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] tab [NUM_ENTRIES];
  logic [3:0]        exp_q [$];
  int                checks = 0;
  int                errors = 0;
  int                kcnt   = 0;

  pulse_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_bus ();

  pulse_seq #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_ENTRIES(NUM_ENTRIES)
  ) dut (
    .clk_SEQ  (clk_SEQ),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .ram      (ram_bus.master),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done),
    .seg_idx  (seg_idx)
  );

  always #5 clk_SEQ = ~clk_SEQ;

  // Pattern RAM model: registered read, data valid one cycle after the address
  always @(posedge clk_SEQ) ram_bus.ram_data <= mem[ram_bus.ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_sample(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    check($sformatf("%s k=%0d {pulse,busy,done,rw}", tag, kcnt),
          {12'd0, pulse_out, busy, done, ram_bus.ram_RW}, {12'd0, e});
    kcnt++;
  endtask

  // Expected samples taken #1 after each edge, starting with the edge sampling start
  task automatic push_model(input bit lp, input int cap);
    int i;
    bit fin;
    i   = 0;
    fin = 1'b0;
    exp_q.delete();
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    while (!fin && exp_q.size() < cap) begin
      if (tab[i] == '0) begin
        if (i == 0 || !lp) begin
          exp_q.push_back(4'b0010);
          fin = 1'b1;
        end else begin
          // terminating zero is fetched with pulse low, then index 0 is refetched
          exp_q.push_back(4'b0100);
          exp_q.push_back(4'b0100);
          i = 0;
        end
      end else begin
        repeat (int'(tab[i]) + 2) exp_q.push_back({(i % 2 == 0), 3'b100});
        if (i == NUM_ENTRIES - 1) begin
          if (!lp) begin
            exp_q.push_back(4'b0010);
            fin = 1'b1;
          end else begin
            i = 0;
          end
        end else begin
          i++;
        end
      end
    end
    while (exp_q.size() > cap) void'(exp_q.pop_back());
  endtask

  task automatic begin_seq(input bit lp, input int cap, input string tag);
    for (int j = 0; j < 16; j++) mem[j] = (j < NUM_ENTRIES) ? tab[j] : '0;
    loop_en = lp;
    push_model(lp, cap);
    start = 1'b1;
    @(posedge clk_SEQ);
    #1;
    start = 1'b0;
    kcnt  = 0;
    check_sample(tag);
  endtask

  task automatic drain(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      if (exp_q.size() > 0) begin
        @(posedge clk_SEQ);
        #1;
        check_sample(tag);
      end
    end
  endtask

  task automatic drain_all(input string tag);
    while (exp_q.size() > 0) begin
      @(posedge clk_SEQ);
      #1;
      check_sample(tag);
    end
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    @(posedge clk_SEQ);
    #1;
    stop = 1'b0;
    check(tag, {13'd0, pulse_out, busy, done}, 16'd0);
  endtask

  task automatic set_ramp();
    for (int j = 0; j < NUM_ENTRIES; j++) tab[j] = DATA_W'(j + 1);
  endtask

  task automatic set_zero();
    for (int j = 0; j < NUM_ENTRIES; j++) tab[j] = '0;
  endtask

  initial begin
    for (int j = 0; j < 16; j++) mem[j] = '0;
    #3;
    rst_n = 1'b0;
    #1;
    check("reset pulse_out", {15'd0, pulse_out}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset done", {15'd0, done}, 16'd0);
    check("reset seg_idx", {12'd0, seg_idx}, 16'd0);
    check("reset ram_addr", {12'd0, ram_bus.ram_addr}, 16'd0);
    check("reset ram_RW", {15'd0, ram_bus.ram_RW}, 16'd0);
    repeat (2) @(posedge clk_SEQ);
    @(negedge clk_SEQ);
    rst_n = 1'b1;
    @(posedge clk_SEQ);
    #1;

    // Full ramp, no loop; a start pulse mid-run must be ignored
    set_ramp();
    begin_seq(1'b0, 1000, "ramp");
    drain(20, "ramp");
    start = 1'b1;
    drain(1, "ramp_busy_start");
    start = 1'b0;
    drain_all("ramp");
    @(posedge clk_SEQ);
    #1;
    check("ramp done_one_cycle", {14'd0, busy, done}, 16'd0);

    // Zero at index 2 with looping restarts at index 0
    set_zero();
    tab[0] = 8'd4;
    tab[1] = 8'd2;
    begin_seq(1'b1, 50, "zero_loop");
    drain_all("zero_loop");
    do_stop("zero_loop stop");

    // Zero at index 0 ends even with looping
    set_zero();
    begin_seq(1'b1, 1000, "empty");
    drain_all("empty");
    @(posedge clk_SEQ);
    #1;
    check("empty idle", {13'd0, pulse_out, busy, done}, 16'd0);

    // Full table looping: two full 52-cycle periods plus wrap
    set_ramp();
    begin_seq(1'b1, 2 + 52 * 2 + 5, "full_loop");
    drain_all("full_loop");
    do_stop("full_loop stop");

    // Stop in the HOLD of index 2 (high), then replay from index 0
    begin_seq(1'b0, 11, "stop_mid");
    drain_all("stop_mid");
    check("stop_mid seg_idx", {12'd0, seg_idx}, 16'd2);
    do_stop("stop_mid stop");
    begin_seq(1'b0, 1000, "replay");
    drain_all("replay");

    // Maximum segment value
    set_zero();
    tab[0] = 8'd255;
    begin_seq(1'b0, 1000, "max255");
    drain_all("max255");

    // Asynchronous reset mid-HOLD clears outputs without a clock edge
    set_ramp();
    begin_seq(1'b0, 11, "async");
    drain_all("async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async pulse_out", {15'd0, pulse_out}, 16'd0);
    check("async busy", {15'd0, busy}, 16'd0);
    check("async seg_idx", {12'd0, seg_idx}, 16'd0);
    check("async ram_addr", {12'd0, ram_bus.ram_addr}, 16'd0);
    @(negedge clk_SEQ);
    rst_n = 1'b1;
    @(posedge clk_SEQ);
    #1;
    check("async idle", {12'd0, pulse_out, busy, done, ram_bus.ram_RW}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
